// File: rtl/conv2d_engine_if.sv
// conv2d_engine_if: start/config handshake plus shared data-memory port of conv2d_engine
// Signals: start, img_base, flt_base, out_base, shift, sat_mode, rd_data (towards engine);
//   rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done (from engine).
// Modports: master = sequencer/memory side, slave = engine side.
interface conv2d_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] img_base;
  logic [ADDR_W-1:0] flt_base;
  logic [ADDR_W-1:0] out_base;
  logic [4:0]        shift;
  logic              sat_mode;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  modport master (
    output start, img_base, flt_base, out_base, shift, sat_mode, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
  modport slave (
    input  start, img_base, flt_base, out_base, shift, sat_mode, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv2d_engine.sv
// conv2d_engine: K x K strided 2-D convolution of an IMG_W x IMG_W image in shared memory
// Ports: clk_i rising-edge clock; rst_ni asynchronous active-low reset;
//   bus (conv2d_engine_if.slave): start/config inputs, busy/done status, memory read port
//   (rd_en/rd_addr out, rd_data valid one cycle later) and write port (wr_en/wr_addr/wr_data).
module conv2d_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IMG_W  = 8,
  parameter int K      = 4,
  parameter int STRIDE = 1,
  parameter int ACC_W  = 2*DATA_W+$clog2(K*K)+1
) (
  input logic            clk_i,
  input logic            rst_ni,
  conv2d_engine_if.slave bus
);
  localparam int KK  = K*K;
  localparam int OUT = (IMG_W-K)/STRIDE+1;
  localparam int TW  = $clog2(KK+1);
  localparam int IW  = KK > 1 ? $clog2(KK) : 1;
  localparam int KW  = $clog2(K+1);
  localparam int OW  = $clog2(OUT+1);
  localparam int PW  = 2*DATA_W;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [KW-1:0]     u_q, u_d, v_q, v_d;
  logic [OW-1:0]     r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0] img_q, flt_q, out_q;
  logic [4:0]        sh_q;
  logic              sat_q;
  logic              cap_q, mac_q;
  logic [IW-1:0]     idx_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] filt_q [KK];
  logic              accept, load_rd, mac_rd, rd_en, wr_en, last_tap, v_last, last_out;
  logic [ADDR_W-1:0] pix_addr;
  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  q;
  assign accept   = state_q == S_IDLE && bus.start;
  assign load_rd  = state_q == S_LOAD && t_q != TW'(KK);
  assign mac_rd   = state_q == S_MAC;
  assign rd_en    = load_rd || mac_rd;
  assign wr_en    = state_q == S_WRITE;
  assign last_tap = t_q == TW'(KK-1);
  assign v_last   = v_q == KW'(K-1);
  assign last_out = r_q == OW'(OUT-1) && c_q == OW'(OUT-1);
  assign pix_addr = img_q + ADDR_W'((32'(r_q)*STRIDE + 32'(u_q))*IMG_W + 32'(c_q)*STRIDE + 32'(v_q));
  // Product uses the tap index registered alongside the read, so it lines up with rd_data.
  assign prod     = PW'(bus.rd_data) * PW'(filt_q[idx_q]);
  assign q        = acc_q >> sh_q;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = mac_rd ? pix_addr : load_rd ? flt_q + ADDR_W'(t_q) : '0;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_en ? out_q + ADDR_W'(32'(r_q)*OUT + 32'(c_q)) : '0;
  assign bus.wr_data = !wr_en ? '0 : (sat_q && |q[ACC_W-1:DATA_W]) ? '1 : q[DATA_W-1:0];
  assign bus.busy    = state_q != S_IDLE && state_q != S_FIN;
  assign bus.done    = state_q == S_FIN;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    u_d = u_q;
    v_d = v_q;
    r_d = r_q;
    c_d = c_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          t_d = '0;
          u_d = '0;
          v_d = '0;
          r_d = '0;
          c_d = '0;
        end
      end
      // Extra cycle at t == KK only captures the last filter tap.
      S_LOAD: begin
        t_d = t_q == TW'(KK) ? '0 : t_q + 1'b1;
        state_d = t_q == TW'(KK) ? S_MAC : S_LOAD;
      end
      S_MAC: begin
        t_d = last_tap ? '0 : t_q + 1'b1;
        v_d = v_last ? '0 : v_q + 1'b1;
        u_d = !v_last ? u_q : u_q == KW'(K-1) ? '0 : u_q + 1'b1;
        state_d = last_tap ? S_DRAIN : S_MAC;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        c_d = c_q == OW'(OUT-1) ? '0 : c_q + 1'b1;
        r_d = last_out ? '0 : c_q == OW'(OUT-1) ? r_q + 1'b1 : r_q;
        state_d = last_out ? S_FIN : S_MAC;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      t_q <= '0;
      u_q <= '0;
      v_q <= '0;
      r_q <= '0;
      c_q <= '0;
      img_q <= '0;
      flt_q <= '0;
      out_q <= '0;
      sh_q <= '0;
      sat_q <= 1'b0;
      cap_q <= 1'b0;
      mac_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
      for (int i = 0; i < KK; i++) filt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      u_q <= u_d;
      v_q <= v_d;
      r_q <= r_d;
      c_q <= c_d;
      cap_q <= rd_en;
      mac_q <= mac_rd;
      idx_q <= IW'(t_q);
      if (accept) begin
        img_q <= bus.img_base;
        flt_q <= bus.flt_base;
        out_q <= bus.out_base;
        sh_q <= bus.shift;
        sat_q <= bus.sat_mode;
      end
      if (cap_q && !mac_q) filt_q[idx_q] <= bus.rd_data;
      // Tap 0 starts a new output, so the accumulator is loaded rather than added.
      if (cap_q && mac_q) acc_q <= (idx_q == '0 ? '0 : acc_q) + ACC_W'(prod);
    end
  end
endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: directed checks of three conv2d_engine configurations with memory models
module tb_conv2d_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [7:0] img_base = '0;
  logic [7:0] flt_base = '0;
  logic [7:0] out_base = '0;
  logic [4:0] shift = '0;
  logic       sat = 1'b0;
  logic [7:0] mem [3][256];
  logic [7:0] rdd [3];
  int         wr_cnt [3];
  int         done_cnt [3];
  int         clash [3];
  int         n_chk = 0;
  int         n_pass = 0;
  wire [2:0]  done_v, busy_v;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv2d_engine_if #(.DATA_W(8), .ADDR_W(8)) bus ();
    conv2d_engine #(.DATA_W(8), .ADDR_W(8), .IMG_W(g == 0 ? 4 : 8), .K(g == 0 ? 2 : 4),
                    .STRIDE(g == 2 ? 2 : 1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    assign bus.start = start_v[g];
    assign bus.img_base = img_base;
    assign bus.flt_base = flt_base;
    assign bus.out_base = out_base;
    assign bus.shift = shift;
    assign bus.sat_mode = sat;
    assign bus.rd_data = rdd[g];
    assign done_v[g] = bus.done;
    assign busy_v[g] = bus.busy;
    initial begin
      wr_cnt[g] = 0;
      done_cnt[g] = 0;
      clash[g] = 0;
    end
    always @(posedge clk) begin
      if (bus.rd_en) rdd[g] <= mem[g][bus.rd_addr];
      if (bus.wr_en) mem[g][bus.wr_addr] = bus.wr_data;
    end
    always @(negedge clk) begin
      if (bus.wr_en) wr_cnt[g]++;
      if (bus.done) done_cnt[g]++;
      if (bus.rd_en && bus.wr_en) clash[g]++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic fill(input int s, input int base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) mem[s][base+i] = v;
  endtask
  task automatic check_all(input string tag, input int s, input int base, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 32'(mem[s][base+i]), 32'(v));
  endtask
  // Starts a pass on engine s and returns the done cycle (0 on timeout) and done pulses seen.
  // With poke set, start is re-pulsed and the config inputs are altered mid-pass.
  task automatic run(input int s, input bit poke, output int cyc, output int nd);
    int d0;
    d0 = done_cnt[s];
    cyc = 0;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    for (int n = 1; n <= 1000 && cyc == 0; n++) begin
      @(negedge clk);
      if (done_v[s]) cyc = n;
      if (poke && n == 10) begin
        start_v[s] = 1'b1;
        img_base = 8'h00;
        out_base = 8'h60;
        shift = 5'd3;
        sat = 1'b0;
      end
      if (poke && n == 11) start_v[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    nd = done_cnt[s] - d0;
  endtask
  initial begin
    int cyc, nd, w0;
    for (int s = 0; s < 3; s++) fill(s, 0, 256, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_v), 0);
    check("rst_done", 32'(done_v), 0);
    check("rst_rd_en", 32'(g_dut[0].bus.rd_en), 0);
    check("rst_rd_addr", 32'(g_dut[0].bus.rd_addr), 0);
    check("rst_wr_en", 32'(g_dut[0].bus.wr_en), 0);
    check("rst_wr_addr", 32'(g_dut[0].bus.wr_addr), 0);
    check("rst_wr_data", 32'(g_dut[0].bus.wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill(0, 16, 16, 8'd1);
    fill(0, 48, 4, 8'd1);
    fill(0, 64, 10, 8'hAA);
    img_base = 8'd16; flt_base = 8'd48; out_base = 8'd64; shift = 5'd0; sat = 1'b1;
    w0 = wr_cnt[0];
    run(0, 1'b0, cyc, nd);
    check("a_cycles", 32'(cyc), 60);
    check("a_done", 32'(nd), 1);
    check("a_writes", 32'(wr_cnt[0] - w0), 9);
    check_all("a_out", 0, 64, 9, 8'd4);
    check("a_guard", 32'(mem[0][73]), 32'hAA);
    fill(1, 0, 64, 8'd255);
    fill(1, 64, 16, 8'd255);
    img_base = 8'd0; flt_base = 8'd64; out_base = 8'd128; shift = 5'd0; sat = 1'b1;
    w0 = wr_cnt[1];
    run(1, 1'b0, cyc, nd);
    check("b_cycles", 32'(cyc), 468);
    check("b_writes", 32'(wr_cnt[1] - w0), 25);
    check_all("b_sat", 1, 128, 25, 8'd255);
    fill(1, 128, 25, 8'd0);
    sat = 1'b0;
    run(1, 1'b0, cyc, nd);
    check_all("b_trunc", 1, 128, 25, 8'd16);
    fill(1, 128, 25, 8'd0);
    shift = 5'd4; sat = 1'b1;
    run(1, 1'b0, cyc, nd);
    check("b_sh4_first", 32'(mem[1][128]), 255);
    check("b_sh4_last", 32'(mem[1][152]), 255);
    fill(1, 128, 25, 8'd0);
    shift = 5'd12; sat = 1'b0;
    run(1, 1'b0, cyc, nd);
    check("b_sh12_first", 32'(mem[1][128]), 254);
    check("b_sh12_last", 32'(mem[1][152]), 254);
    for (int i = 0; i < 64; i++) mem[2][i] = 8'(i);
    fill(2, 64, 16, 8'd0);
    mem[2][64] = 8'd1;
    fill(2, 128, 16, 8'hAA);
    img_base = 8'd0; flt_base = 8'd64; out_base = 8'd128; shift = 5'd0; sat = 1'b1;
    w0 = wr_cnt[2];
    run(2, 1'b0, cyc, nd);
    check("c_cycles", 32'(cyc), 180);
    check("c_writes", 32'(wr_cnt[2] - w0), 9);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("c_out[%0d,%0d]", r, c), 32'(mem[2][128+r*3+c]), 32'(r*16 + c*2));
    check("c_guard", 32'(mem[2][137]), 32'hAA);
    for (int i = 0; i < 16; i++) mem[0][16+i] = 8'(i);
    for (int i = 0; i < 4; i++) mem[0][48+i] = 8'(i + 1);
    fill(0, 64, 9, 8'd0);
    fill(0, 96, 9, 8'h55);
    img_base = 8'd16; flt_base = 8'd48; out_base = 8'd64; shift = 5'd0; sat = 1'b1;
    w0 = wr_cnt[0];
    run(0, 1'b1, cyc, nd);
    check("p_cycles", 32'(cyc), 60);
    check("p_done", 32'(nd), 1);
    check("p_writes", 32'(wr_cnt[0] - w0), 9);
    check("p_busy", 32'(busy_v[0]), 0);
    check("p_alt_out", 32'(mem[0][96]), 32'h55);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("p_out[%0d,%0d]", r, c), 32'(mem[0][64+r*3+c]), 32'(10*(4*r+c) + 34));
    img_base = 8'd16; flt_base = 8'd48; out_base = 8'd64; shift = 5'd0; sat = 1'b1;
    fill(0, 64, 9, 8'd0);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("r_in_mac", 32'(g_dut[0].bus.rd_en), 1);
    check("r_mac_addr", 32'(g_dut[0].bus.rd_addr), 22);
    w0 = wr_cnt[0];
    nd = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("r_busy", 32'(busy_v[0]), 0);
    check("r_rd_en", 32'(g_dut[0].bus.rd_en), 0);
    check("r_rd_addr", 32'(g_dut[0].bus.rd_addr), 0);
    check("r_wr_en", 32'(g_dut[0].bus.wr_en), 0);
    check("r_done", 32'(done_v[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("r_no_write", 32'(wr_cnt[0] - w0), 0);
    check("r_no_done", 32'(done_cnt[0] - nd), 0);
    check("r_out1_kept", 32'(mem[0][65]), 44);
    check("r_out2_none", 32'(mem[0][66]), 0);
    fill(0, 64, 9, 8'd0);
    run(0, 1'b0, cyc, nd);
    check("r2_cycles", 32'(cyc), 60);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("r2_out[%0d,%0d]", r, c), 32'(mem[0][64+r*3+c]), 32'(10*(4*r+c) + 34));
    check("rd_wr_clash", 32'(clash[0] + clash[1] + clash[2]), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
- Parametrised successor of the fixed 8x8-window / 4x4-filter convolution top.
- Runs a complete K x K 2-D convolution of an IMG_W x IMG_W unsigned image held in the shared data memory, with configurable stride.
- Loads the filter into internal registers, then computes one multiply-accumulate (MAC) per cycle.
- Each result is shifted and quantised (saturate or truncate), then written back to memory.
- A start/busy/done handshake lets a top-level sequencer chain multiple convolution passes.

Parameters:
- DATA_W, 8, pixel/filter/output word width (unsigned).
- ADDR_W, 8, data-memory address width.
- IMG_W, 8, input image side length in pixels.
- K, 4, filter side length; legal range 1..IMG_W.
- STRIDE, 1, window step in both axes; (IMG_W-K) % STRIDE must be 0.
- ACC_W, 2*DATA_W+$clog2(K*K)+1, accumulator width; this default never overflows.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, request a pass; sampled only in IDLE.
- img_base, input, ADDR_W, address of image pixel (0,0); image is row-major.
- flt_base, input, ADDR_W, address of filter tap (0,0); filter is row-major.
- out_base, input, ADDR_W, address of output (0,0); output is row-major.
- shift, input, 5, right-shift applied to the accumulator before quantisation.
- sat_mode, input, 1, 1 = saturate to 2^DATA_W-1, 0 = keep low DATA_W bits.
- rd_en, output, 1, memory read strobe.
- rd_addr, output, ADDR_W, memory read address.
- rd_data, input, DATA_W, read data, valid exactly 1 cycle after rd_en.
- wr_en, output, 1, memory write strobe.
- wr_addr, output, ADDR_W, memory write address.
- wr_data, output, DATA_W, quantised result.
- busy, output, 1, high from the start-accept edge until done.
- done, output, 1, one-cycle pulse when the pass completes.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - All outputs 0: rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done.
  - Accumulator, filter registers and all counters cleared.
- Derived constant: OUT = (IMG_W-K)/STRIDE + 1.
- Configuration latch: img_base, flt_base, out_base, shift and sat_mode are latched on the start-accept edge. Later changes have no effect on the running pass.
- IDLE:
  - start=1 moves to LOAD_F, sets busy=1, clears tap counter t and output counters (r,c).
  - start while busy is ignored.
- LOAD_F:
  - For t = 0..K*K-1: rd_en=1, rd_addr = flt_base + t.
  - Each rd_data is captured into filter[t] one cycle after its read.
  - Lasts K*K+1 cycles (includes the final capture), then goes to MAC.
- MAC (per output (r,c); tap counters u,v with t = u*K+v):
  - rd_en=1, rd_addr = img_base + (r*STRIDE+u)*IMG_W + (c*STRIDE+v).
  - One cycle later: acc += rd_data * filter[t-1 registered].
  - On the first tap of each output the accumulator is loaded, not added.
  - After K*K issue cycles, go to DRAIN.
- DRAIN: one cycle; the last product is accumulated; rd_en=0.
- WRITE: one cycle.
  - q = acc >> shift.
  - wr_data = (sat_mode && q > 2^DATA_W-1) ? all-ones : q[DATA_W-1:0].
  - wr_en=1, wr_addr = out_base + r*OUT + c.
  - Then advance c, wrapping to 0 and incrementing r.
  - If (r,c) was (OUT-1,OUT-1), go to FINISH; otherwise go back to MAC.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. A start in the same cycle is not accepted.
- Timing:
  - Per-output cost: K*K+2 cycles.
  - done asserts (K*K+1) + OUT*OUT*(K*K+2) + 1 cycles after the start-accept edge.
- Exclusivity: rd_en and wr_en are never high in the same cycle. Memory read and write addresses use ADDR_W wrap-around arithmetic (no error flagging).
- Corner cases:
  - K = IMG_W gives OUT=1: a single output.
  - K=1 degenerates to pixel scaling.
- Reset mid-pass: the pass is aborted immediately, there is no partial write, and done does not pulse.

Test Plan:
- IMG_W=4, K=2, STRIDE=1; image all 1, filter all 1, shift=0, sat=1 -> 9 writes of value 4 at out_base..out_base+8; done at cycle 5+9*6+1=60.
- IMG_W=8, K=4, STRIDE=1; pixel=255, filter=255, shift=0 -> sat=1 writes 255 in all 25 outputs; sat=0 writes 16 (1040400 mod 256).
- IMG_W=8, K=4, STRIDE=2, ramp image p(i,j)=i*8+j, filter with a single 1 at tap (0,0) -> OUT=3; outputs 0,2,4,16,18,20,32,34,36.
- shift=4 with acc=1040400, sat=1 -> q=65025 saturates to 255; shift=12, sat=0 -> 254.
- start pulsed during busy, and base inputs changed mid-pass -> ignored; results match the latched configuration; exactly one done pulse.
- reset asserted in the 3rd MAC cycle of output 2, then start re-issued -> outputs are zero immediately after reset, no stray wr_en occurs, and the fresh pass completes with correct values.
